// File: rtl/axil_regs.sv
// AXI4-Lite slave register block decoding a 4 KB window:
// ID, STATUS, SCRATCH, CTRL and USER0-3, with independent read and write FSMs.
module axil_regs #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'hA11E_0001
) (
  input  logic                      S_AXI_aclk,
  input  logic                      S_AXI_aresetn,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_awaddr,
  input  logic [2:0]                S_AXI_awprot,
  input  logic                      S_AXI_awvalid,
  output logic                      S_AXI_awready,
  input  logic [DATA_WIDTH-1:0]     S_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_wstrb,
  input  logic                      S_AXI_wvalid,
  output logic                      S_AXI_wready,
  output logic [1:0]                S_AXI_bresp,
  output logic                      S_AXI_bvalid,
  input  logic                      S_AXI_bready,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_araddr,
  input  logic [2:0]                S_AXI_arprot,
  input  logic                      S_AXI_arvalid,
  output logic                      S_AXI_arready,
  output logic [DATA_WIDTH-1:0]     S_AXI_rdata,
  output logic [1:0]                S_AXI_rresp,
  output logic                      S_AXI_rvalid,
  input  logic                      S_AXI_rready,
  input  logic [DATA_WIDTH-1:0]     status_in,
  output logic [DATA_WIDTH-1:0]     ctrl_out,
  output logic                      ctrl_wr,
  output logic [4*DATA_WIDTH-1:0]   user_out
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate_q;
  rstate_t rstate_q;

  logic                      awready_q, wready_q, bvalid_q, ctrl_wr_q;
  logic [1:0]                bresp_q;
  logic                      aw_held_q, w_held_q;
  logic [9:0]                awidx_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH/8-1:0]   wstrb_q;

  logic                      arready_q, rvalid_q;
  logic [1:0]                rresp_q;
  logic [DATA_WIDTH-1:0]     rdata_q;

  logic [DATA_WIDTH-1:0]     scratch_q, ctrl_q;
  logic [3:0][DATA_WIDTH-1:0] user_q;

  logic                      aw_hs, w_hs, have_aw, have_w, wr_ok;
  logic [9:0]                wr_idx;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [DATA_WIDTH/8-1:0]   wr_strb;
  logic                      rd_ok;
  logic [9:0]                rd_idx;
  logic [DATA_WIDTH-1:0]     rd_val;

  // Protection bits, upper address bits and byte offset are not decoded.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_awprot, S_AXI_arprot,
                         S_AXI_awaddr[ADDR_WIDTH-1:12], S_AXI_awaddr[1:0],
                         S_AXI_araddr[ADDR_WIDTH-1:12], S_AXI_araddr[1:0]};

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0]   old_v,
    input logic [DATA_WIDTH-1:0]   new_v,
    input logic [DATA_WIDTH/8-1:0] strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int unsigned i = 0; i < DATA_WIDTH/8; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Write-side handshakes; a captured AW/W takes precedence over the live bus.
  always_comb begin
    aw_hs   = S_AXI_awvalid && awready_q;
    w_hs    = S_AXI_wvalid && wready_q;
    have_aw = aw_held_q || aw_hs;
    have_w  = w_held_q || w_hs;
    wr_idx  = aw_held_q ? awidx_q : S_AXI_awaddr[11:2];
    wr_data = w_held_q ? wdata_q : S_AXI_wdata;
    wr_strb = w_held_q ? wstrb_q : S_AXI_wstrb;
    wr_ok   = (wr_idx[9:3] == '0);
  end

  // Read decode of the live AR address, sampled at the AR handshake.
  always_comb begin
    rd_idx = S_AXI_araddr[11:2];
    rd_ok  = (rd_idx[9:3] == '0);
    rd_val = '0;
    case (rd_idx[2:0])
      3'd0:    rd_val = ID_VALUE;
      3'd1:    rd_val = status_in;
      3'd2:    rd_val = scratch_q;
      3'd3:    rd_val = ctrl_q;
      default: rd_val = user_q[rd_idx[1:0]];
    endcase
    if (!rd_ok) rd_val = '0;
  end

  // Write FSM: the commit happens on the edge that completes the second of AW/W,
  // bypassing the capture registers when both arrive together.
  always_ff @(posedge S_AXI_aclk) begin
    if (!S_AXI_aresetn) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      ctrl_wr_q <= 1'b0;
      scratch_q <= '0;
      ctrl_q    <= '0;
      user_q    <= '0;
    end else begin
      ctrl_wr_q <= 1'b0;
      case (wstate_q)
        W_IDLE: begin
          if (have_aw && have_w) begin
            if (wr_ok) begin
              case (wr_idx[2:0])
                3'd2: scratch_q <= merge_bytes(scratch_q, wr_data, wr_strb);
                3'd3: begin
                  ctrl_q    <= merge_bytes(ctrl_q, wr_data, wr_strb);
                  ctrl_wr_q <= 1'b1;
                end
                default: begin
                  if (wr_idx[2])
                    user_q[wr_idx[1:0]] <= merge_bytes(user_q[wr_idx[1:0]], wr_data, wr_strb);
                end
              endcase
            end
            bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            bvalid_q  <= 1'b1;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            wstate_q  <= W_RESP;
          end else begin
            aw_held_q <= have_aw;
            w_held_q  <= have_w;
            if (aw_hs) awidx_q <= S_AXI_awaddr[11:2];
            if (w_hs) begin
              wdata_q <= S_AXI_wdata;
              wstrb_q <= S_AXI_wstrb;
            end
            awready_q <= !have_aw;
            wready_q  <= !have_w;
          end
        end
        W_RESP: begin
          if (S_AXI_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Read FSM: data and response latched at the AR handshake, held until accepted.
  always_ff @(posedge S_AXI_aclk) begin
    if (!S_AXI_aresetn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (S_AXI_arvalid && arready_q) begin
            rdata_q   <= rd_val;
            rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rstate_q  <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_awready = awready_q;
  assign S_AXI_wready  = wready_q;
  assign S_AXI_bvalid  = bvalid_q;
  assign S_AXI_bresp   = bresp_q;
  assign S_AXI_arready = arready_q;
  assign S_AXI_rvalid  = rvalid_q;
  assign S_AXI_rdata   = rdata_q;
  assign S_AXI_rresp   = rresp_q;
  assign ctrl_out      = ctrl_q;
  assign ctrl_wr       = ctrl_wr_q;
  assign user_out      = user_q;

endmodule

// File: tb/tb_axil_regs.sv
// Self-checking bench for axil_regs: directed AXI-Lite transactions against a
// register-map model, plus a per-cycle compare of the sideband outputs.
module tb_axil_regs;

  localparam logic [31:0] ID = 32'hA11E_0001;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [31:0]  awaddr, wdata, araddr, rdata, status_in, ctrl_out;
  logic [2:0]   awprot, arprot;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready, ctrl_wr;
  logic [1:0]   bresp, rresp;
  logic [127:0] user_out;

  axil_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_VALUE(ID)) dut (
    .S_AXI_aclk(clk), .S_AXI_aresetn(aresetn),
    .S_AXI_awaddr(awaddr), .S_AXI_awprot(awprot), .S_AXI_awvalid(awvalid), .S_AXI_awready(awready),
    .S_AXI_wdata(wdata), .S_AXI_wstrb(wstrb), .S_AXI_wvalid(wvalid), .S_AXI_wready(wready),
    .S_AXI_bresp(bresp), .S_AXI_bvalid(bvalid), .S_AXI_bready(bready),
    .S_AXI_araddr(araddr), .S_AXI_arprot(arprot), .S_AXI_arvalid(arvalid), .S_AXI_arready(arready),
    .S_AXI_rdata(rdata), .S_AXI_rresp(rresp), .S_AXI_rvalid(rvalid), .S_AXI_rready(rready),
    .status_in(status_in), .ctrl_out(ctrl_out), .ctrl_wr(ctrl_wr), .user_out(user_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Register-map model: index = addr[4:2] within offsets 0x000-0x01F.
  logic [31:0] m_reg [8];
  logic [31:0] m_status;
  int          pulse_at = -10;
  int          gcyc = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) gcyc <= gcyc + 1;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[11:5] != 7'd0) return 32'h0;
    if (a[4:2] == 3'd0) return ID;
    if (a[4:2] == 3'd1) return m_status;
    return m_reg[a[4:2]];
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    if (a[11:5] != 7'd0) return;
    idx = int'(a[4:2]);
    if (idx < 2) return;
    for (int b = 0; b < 4; b++)
      if (s[b]) m_reg[idx][8*b +: 8] = d[8*b +: 8];
    if (idx == 3) pulse_at = gcyc;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
    pulse_at = -10;
  endfunction

  // Per-cycle compare of the register-mirroring outputs.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ctrl_out", ctrl_out, m_reg[3]);
      check("user_out", user_out, {m_reg[7], m_reg[6], m_reg[5], m_reg[4]});
      check("ctrl_wr", ctrl_wr, (gcyc == pulse_at));
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input logic [1:0] exp_resp);
    bit aw_done = 0, w_done = 0, b_done = 0;
    bit aw_rdy, w_rdy, bv;
    int cyc = 0, first_b = -1, bv_cnt = 0;
    int mx;
    mx = (aw_dly > w_dly) ? aw_dly : w_dly;
    awaddr = a; wdata = d; wstrb = s;
    while (!b_done && cyc < 60) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_rdy = awready; w_rdy = wready; bv = bvalid;
      bready = bv && (bv_cnt >= b_dly);
      if (bv) begin
        check("bresp", bresp, exp_resp);
        check("aw/w ready low while bvalid", {awready, wready}, 2'b00);
      end
      @(posedge clk); #1;
      if (awvalid && aw_rdy) aw_done = 1;
      if (wvalid && w_rdy) w_done = 1;
      if (bv && bready) b_done = 1;
      if (bv) bv_cnt++;
      if (!bv && bvalid && first_b < 0) begin
        first_b = cyc + 1;
        model_write(a, d, s);
      end
      cyc++;
    end
    awvalid = 0; wvalid = 0; bready = 0;
    if (!b_done) check("write timeout", 1'b0, 1'b1);
    else check("write latency", first_b - mx, 1);
  endtask

  task automatic do_read(input logic [31:0] a, input int r_dly,
                         input logic [31:0] exp_d, input logic [1:0] exp_resp);
    bit ar_done = 0, r_done = 0;
    bit ar_rdy, rv;
    int cyc = 0, hs = -1, first = -1, rv_cnt = 0;
    araddr = a;
    while (!r_done && cyc < 60) begin
      arvalid = !ar_done;
      ar_rdy = arready; rv = rvalid;
      rready = rv && (rv_cnt >= r_dly);
      if (rv) begin
        check("rdata", rdata, exp_d);
        check("rresp", rresp, exp_resp);
        check("arready low while rvalid", arready, 1'b0);
      end
      @(posedge clk); #1;
      if (arvalid && ar_rdy) begin ar_done = 1; hs = cyc; end
      if (rv && rready) r_done = 1;
      if (rv) rv_cnt++;
      if (!rv && rvalid && first < 0) first = cyc + 1;
      cyc++;
    end
    arvalid = 0; rready = 0;
    if (!r_done) check("read timeout", 1'b0, 1'b1);
    else check("read latency", first - hs, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_v;
    aresetn = 0; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0; status_in = 0;
    m_status = 0;
    model_clear();

    // Reset: readies and valids low, then readies rise on first edge out of reset.
    repeat (3) @(posedge clk);
    #1;
    check("readies in reset", {awready, wready, arready}, 3'b000);
    check("valids in reset", {bvalid, rvalid}, 2'b00);
    check("ctrl/user in reset", {ctrl_out, user_out}, 160'h0);
    aresetn = 1;
    @(posedge clk); #1;
    check("readies after reset", {awready, wready, arready}, 3'b111);
    chk_en = 1;

    // ID and STATUS; status is sampled at the AR handshake.
    check("model pin id", model_read(32'h0), 32'hA11E_0001);
    do_read(32'h000, 0, 32'hA11E_0001, 2'b00);
    status_in = 32'h1234_5678; m_status = 32'h1234_5678;
    fork
      do_read(32'h004, 3, 32'h1234_5678, 2'b00);
      begin repeat (2) @(posedge clk); #2 status_in = 32'hDEAD_0000; end
    join
    m_status = 32'hDEAD_0000;

    // Same-cycle AW/W, full strobe.
    do_write(32'h010, 32'hB00B_FEED, 4'hF, 0, 0, 0, 2'b00);
    check("user0 literal", user_out[31:0], 32'hB00B_FEED);
    do_read(32'h010, 0, 32'hB00B_FEED, 2'b00);

    // Partial strobe merge.
    do_write(32'h014, 32'hFF00_0077, 4'hF, 0, 0, 0, 2'b00);
    do_write(32'h014, 32'h3000_0044, 4'h3, 0, 0, 0, 2'b00);
    check("model pin user1", m_reg[5], 32'hFF00_0044);
    do_read(32'h014, 1, 32'hFF00_0044, 2'b00);

    // AW three cycles ahead of W, B back-pressured for five cycles; CTRL pulse.
    do_write(32'h00C, 32'h0000_0001, 4'hF, 0, 3, 5, 2'b00);
    check("ctrl_out literal", ctrl_out, 32'h1);

    // W ahead of AW into SCRATCH, then readback.
    do_write(32'h008, 32'h1357_9BDF, 4'hF, 2, 0, 1, 2'b00);
    do_read(32'h008, 0, 32'h1357_9BDF, 2'b00);

    // Writes to read-only registers: OKAY, no effect.
    do_write(32'h000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 2'b00);
    do_read(32'h000, 0, 32'hA11E_0001, 2'b00);
    do_write(32'h004, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 2'b00);

    // Out-of-range boundaries and ignored address bits.
    do_write(32'h040, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 2'b10);
    do_write(32'h020, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 2'b10);
    do_read(32'h800, 0, 32'h0, 2'b10);
    do_read(32'h020, 0, 32'h0, 2'b10);
    do_write(32'h01C, 32'hA5A5_0F0F, 4'hF, 0, 0, 0, 2'b00);
    do_read(32'h01C, 0, 32'hA5A5_0F0F, 2'b00);
    do_write(32'h00B, 32'h0BAD_F00D, 4'hC, 0, 0, 0, 2'b00);
    do_read(32'h00A, 0, 32'h0BAD_9BDF, 2'b00);
    do_read(32'h0000_1010, 0, model_read(32'h010), 2'b00);

    // Simultaneous read and write of the same register: read sees the old value.
    old_v = model_read(32'h008);
    fork
      do_write(32'h008, 32'h5555_AAAA, 4'hF, 0, 0, 0, 2'b00);
      do_read(32'h008, 0, old_v, 2'b00);
    join
    do_read(32'h008, 0, 32'h5555_AAAA, 2'b00);

    // Reset while bvalid and rvalid are both pending.
    chk_en = 0;
    awaddr = 32'h00C; wdata = 32'h0000_0007; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 32'h008; arvalid = 1; bready = 0; rready = 0;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("valids before reset", {bvalid, rvalid}, 2'b11);
    aresetn = 0;
    @(posedge clk); #1;
    check("valids/readies after mid reset", {bvalid, rvalid, awready, wready, arready}, 5'b0);
    check("outputs after mid reset", {ctrl_wr, ctrl_out, user_out}, 161'h0);
    check("rdata/resp after mid reset", {rdata, rresp, bresp}, 36'h0);
    aresetn = 1;
    model_clear();
    @(posedge clk); #1;
    check("readies after mid reset release", {awready, wready, arready}, 3'b111);
    chk_en = 1;
    for (int a = 8; a <= 28; a += 4) do_read(a, 0, 32'h0, 2'b00);
    do_write(32'h018, 32'hCAFE_0001, 4'hF, 0, 0, 0, 2'b00);
    do_read(32'h018, 0, 32'hCAFE_0001, 2'b00);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axil_regs.md
# axil_regs

AXI4-Lite slave register block: the target that the AXI-Lite stimulus master drives in simulation and that the interconnect drives in hardware. It decodes a 4 KB window and implements ID, status, scratch, control and four user registers. Each module window (e.g. 0x0000, 0x1000) is a separate instance; the interconnect or bench decodes the upper address bits. Independent read and write FSMs give one outstanding transaction per direction.

## Interface
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- ADDR_WIDTH, 32, address width; only bits [11:0] are decoded.
- ID_VALUE, 32'hA11E_0001, value returned by the ID register.
- S_AXI_aclk  in  1  clock; all logic on the rising edge.
- S_AXI_aresetn  in  1  reset, synchronous, active-low.
- S_AXI_awaddr/awprot/awvalid/awready, S_AXI_wdata/wstrb/wvalid/wready, S_AXI_bresp/bvalid/bready, S_AXI_araddr/arprot/arvalid/arready, S_AXI_rdata/rresp/rvalid/rready: standard AXI4-Lite slave channels, widths per parameters. awprot and arprot are ignored.
- status_in  in  32  live status, readable at 0x004.
- ctrl_out  out  32  CTRL register contents.
- ctrl_wr  out  1  one-cycle pulse when a write to CTRL commits.
- user_out  out  128  USER3..USER0 concatenated, with USER0 in [31:0].

## Operation
- Register map, by offset = addr[11:0]:
  - 0x000 ID: RO, returns ID_VALUE.
  - 0x004 STATUS: RO, returns status_in sampled at AR handshake.
  - 0x008 SCRATCH: RW.
  - 0x00C CTRL: RW.
  - 0x010–0x01C USER0–3: RW.
- addr[1:0] is ignored.
- Offsets 0x020–0xFFF are out of range:
  - Write: no effect, bresp = 2'b10 (SLVERR).
  - Read: rdata = 0, rresp = 2'b10.
- A write to ID or STATUS is ignored and returns OKAY (2'b00). All in-range accesses return OKAY.
- Byte strobes: for each lane i with wstrb[i] = 1, reg[8i+7:8i] takes wdata[8i+7:8i]; other lanes hold.
- Write FSM:
  - States W_IDLE and W_RESP.
  - In W_IDLE, AW and W are captured independently, in either order or in the same cycle. awready is high until AW is captured; wready is high until W is captured.
  - When both are held, the write commits and the FSM enters W_RESP with bvalid = 1.
  - In W_RESP, awready = wready = 0. On bvalid && bready, the FSM returns to W_IDLE and both readies go high the next cycle.
- Read FSM:
  - States R_IDLE (arready = 1) and R_DATA (rvalid = 1, arready = 0).
  - rdata and rresp are latched at the AR handshake and held stable until rvalid && rready.
- Reset, including mid-transaction:
  - All valids and readies go to 0; the FSMs return to IDLE; captured AW/W are discarded.
  - SCRATCH, CTRL and USER0–3 go to 0; ctrl_wr = 0; bresp = rresp = 0; rdata = 0.

## Timing
- awready, wready and arready are 0 during reset and go to 1 on the first edge with aresetn = 1.
- Write latency:
  - AW and W in the same cycle: register updated and bvalid = 1 on the next edge (1 cycle).
  - AW and W split: the commit occurs on the edge after the later of the two handshakes.
- ctrl_wr is high for exactly the cycle after the commit edge, aligned with the first bvalid cycle.
- Read latency: rvalid = 1 on the edge after the AR handshake.
- bvalid and rvalid hold indefinitely under back-pressure; all outputs stay stable while held.
- Simultaneous read and write to the same register with both handshakes on the same edge: the read returns the pre-write value.
- Throughput: one write per 2 cycles and one read per 2 cycles when the ready signals are held high. Reads and writes proceed concurrently.

## Test plan
- Reset, then read 0x000 → rdata = 0xA11E0001, rresp = 0. Read 0x004 with status_in = 0x12345678 → 0x12345678.
- Write 0x010 = 0xB00BFEED with AW and W in the same cycle, wstrb = 0xF → bvalid 1 cycle later, bresp = 0; read 0x010 → 0xB00BFEED; user_out[31:0] = 0xB00BFEED.
- Write 0x014 = 0xFF000077, then write 0x014 = 0x30000044 with wstrb = 0x3 → read 0x014 returns 0xFF000044.
- AW presented 3 cycles before W, with bready held low for 5 cycles → bvalid stays high and stable; write 0x00C = 0x1 gives ctrl_wr high for exactly 1 cycle and ctrl_out = 1.
- Write 0x000 = 0xFFFFFFFF → bresp = 0 and ID unchanged. Write 0x040 → bresp = 2'b10. Read 0x800 → rdata = 0, rresp = 2'b10.
- Assert reset while bvalid = 1 and rvalid = 1 → both are 0 after the edge, all RW registers read 0, and a new transaction completes normally.
